// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory load/fetch arbiter.
// Boot sequencing states, instruction width and out-of-range fill.
package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] OOR_FILL = 16'h0000;

endpackage

// File: rtl/imem_load_arb_if.sv
// Fetch, loader and memory-port signal bundle for imem_load_arb.
// slave is the arbiter side; master is the CPU/loader/RAM side.
interface imem_load_arb_if
  import imem_pkg::*;
#(
  parameter int AW = 3
);

  logic               fetch_req;
  logic [31:0]        fetch_addr;
  logic               fetch_stall;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_data;

  logic               ld_valid;
  logic [AW-1:0]      ld_addr;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               boot_done;
  logic [AW:0]        load_count;

  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_stall,
    output fetch_valid,
    output fetch_data,
    input  ld_valid,
    input  ld_addr,
    input  ld_data,
    input  ld_last,
    output ld_ready,
    output boot_done,
    output load_count,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_stall,
    input  fetch_valid,
    input  fetch_data,
    output ld_valid,
    output ld_addr,
    output ld_data,
    output ld_last,
    input  ld_ready,
    input  boot_done,
    input  load_count,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_load_arb.sv
// Single-port instruction RAM arbiter: boot-load sequencer, then
// fetch-priority arbitration with a starvation guard for loader patches.
module imem_load_arb
  import imem_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  imem_load_arb_if.slave   bus
);

  localparam int WW = $clog2(STARVE_MAX + 1);

  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WMAX = WW'(STARVE_MAX);
  localparam logic [31:0]   LIM  = 32'(2 * DEPTH);

  state_t        state_q;
  state_t        state_d;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [WW-1:0] wait_q;
  logic [WW-1:0] wait_d;
  logic          fv_q;
  logic          inr_q;
  logic          inr;
  logic          acc;
  logic          grant;

  assign inr = bus.fetch_addr < LIM;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    wait_d          = wait_q;
    grant           = 1'b0;
    acc             = 1'b0;
    bus.ld_ready    = 1'b0;
    bus.fetch_stall = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    unique case (state_q)
      LOAD: begin
        bus.ld_ready    = 1'b1;
        bus.fetch_stall = 1'b1;
        wait_d          = '0;
        if (bus.ld_valid) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.ld_addr;
          bus.mem_wdata = bus.ld_data;
          if (cnt_q != FULL)
            cnt_d = cnt_q + 1'b1;
          if (bus.ld_last || cnt_d == FULL)
            state_d = RUN;
        end
      end
      RUN: begin
        // Loader wins only on an idle fetch or once it has waited enough.
        grant = bus.ld_valid &&
                (!bus.fetch_req || wait_q == WMAX);
        acc   = bus.fetch_req && !grant;
        bus.ld_ready    = grant;
        bus.fetch_stall = grant;
        if (grant) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.ld_addr;
          bus.mem_wdata = bus.ld_data;
          wait_d        = '0;
        end else if (acc) begin
          if (inr) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.fetch_addr[AW:1];
          end
          if (bus.ld_valid)
            wait_d = wait_q + 1'b1;
        end
        if (!bus.ld_valid)
          wait_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      wait_q  <= '0;
      fv_q    <= 1'b0;
      inr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      fv_q    <= acc;
      inr_q   <= acc && inr;
    end
  end

  assign bus.fetch_valid = fv_q;
  assign bus.fetch_data  = inr_q ? bus.mem_rdata : OOR_FILL;
  assign bus.boot_done   = (state_q == RUN);
  assign bus.load_count  = cnt_q;

endmodule

// File: tb/tb_imem_load_arb.sv
// Directed bench for imem_load_arb with a behavioural registered-read RAM.
// Boot, fetch, out-of-range, starvation, reset and full-depth scenarios.
module tb_imem_load_arb;
  import imem_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int SMAX  = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imem_load_arb_if #(.AW(AW)) bus ();

  imem_load_arb #(
    .DEPTH(DEPTH),
    .AW(AW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [15:0] tmem [DEPTH];
  logic [15:0] rdq = 16'h0000;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we)
        tmem[bus.mem_addr] <= bus.mem_wdata;
      else
        rdq <= tmem[bus.mem_addr];
    end
  end

  assign bus.mem_rdata = rdq;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = pc;
  endtask

  task automatic ldw(input int a, input logic [15:0] d,
                     input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = AW'(a);
    bus.ld_data  = d;
    bus.ld_last  = last;
  endtask

  logic [15:0] bootw [5];

  initial begin
    bootw = '{16'h8180, 16'h2CB2, 16'hDC67, 16'hDDD9, 16'hFDB1};
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(bus.fetch_stall), 1);
    chk("rst_ready", 32'(bus.ld_ready), 1);
    chk("rst_boot", 32'(bus.boot_done), 0);
    chk("rst_fv", 32'(bus.fetch_valid), 0);
    chk("rst_fd", 32'(bus.fetch_data), 0);
    chk("rst_cnt", 32'(bus.load_count), 0);
    chk("rst_en", 32'(bus.mem_en), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    step();
    reset = 1'b0;

    // Boot five words, last flagged
    for (int i = 0; i < 5; i++) begin
      ldw(i, bootw[i], i == 4);
      fetch(32'h0);
      @(negedge clk);
      chk("boot_we", 32'(bus.mem_we), 1);
      chk("boot_stall", 32'(bus.fetch_stall), 1);
      chk("boot_bd", 32'(bus.boot_done), 0);
      step();
    end
    idle();

    // Fetch PCs 0..8 back-to-back, first in the boot_done cycle
    for (int k = 0; k < 6; k++) begin
      if (k < 5)
        fetch(32'(2 * k));
      else
        bus.fetch_req = 1'b0;
      @(negedge clk);
      if (k == 0) begin
        chk("bd_rise", 32'(bus.boot_done), 1);
        chk("cnt5", 32'(bus.load_count), 5);
        chk("first_acc", 32'(bus.fetch_stall), 0);
        chk("fv_idle", 32'(bus.fetch_valid), 0);
      end else begin
        chk("fetch_fv", 32'(bus.fetch_valid), 1);
        chk("fetch_fd", 32'(bus.fetch_data), 32'(bootw[k-1]));
      end
      step();
    end

    // Out-of-range fetches
    fetch(32'd16);
    @(negedge clk);
    chk("oor_en", 32'(bus.mem_en), 0);
    chk("oor_stall", 32'(bus.fetch_stall), 0);
    step();
    fetch(32'hFFFF_FFFE);
    @(negedge clk);
    chk("oor_en2", 32'(bus.mem_en), 0);
    chk("oor_fv", 32'(bus.fetch_valid), 1);
    chk("oor_fd", 32'(bus.fetch_data), 0);
    step();
    idle();
    @(negedge clk);
    chk("oor_fv2", 32'(bus.fetch_valid), 1);
    chk("oor_fd2", 32'(bus.fetch_data), 0);
    step();

    // Patch with idle fetch: immediate grant, ld_last ignored
    ldw(7, 16'h7E7E, 1'b1);
    @(negedge clk);
    chk("patch_rdy", 32'(bus.ld_ready), 1);
    chk("patch_stall", 32'(bus.fetch_stall), 1);
    step();
    idle();
    @(negedge clk);
    chk("cnt_frozen", 32'(bus.load_count), 5);
    chk("bd_hold", 32'(bus.boot_done), 1);
    step();

    // Starvation: fetch wins cycles 0..3, loader forced in cycle 4
    for (int c = 0; c < 5; c++) begin
      ldw(1, 16'hA5A5, 1'b0);
      fetch(32'h0);
      @(negedge clk);
      chk("stv_rdy", 32'(bus.ld_ready), 32'(c == 4));
      chk("stv_stall", 32'(bus.fetch_stall), 32'(c == 4));
      if (c > 0) begin
        chk("stv_fv", 32'(bus.fetch_valid), 1);
        chk("stv_fd", 32'(bus.fetch_data), 32'h8180);
      end
      step();
    end
    idle();
    fetch(32'd2);
    @(negedge clk);
    chk("stv_fv_gap", 32'(bus.fetch_valid), 0);
    step();
    idle();
    @(negedge clk);
    chk("stv_new_fv", 32'(bus.fetch_valid), 1);
    chk("stv_new_fd", 32'(bus.fetch_data), 32'hA5A5);
    step();

    // Reset with a fetch result pending
    fetch(32'h0);
    step();
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rr_fv", 32'(bus.fetch_valid), 0);
    chk("rr_bd", 32'(bus.boot_done), 0);
    step();
    reset = 1'b0;

    // Partial boot, then reset mid-boot
    for (int i = 0; i < 3; i++) begin
      ldw(5 + i, 16'(16'h5555 + 16'h1111 * i), 1'b0);
      step();
    end
    idle();
    @(negedge clk);
    chk("mid_cnt3", 32'(bus.load_count), 3);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_cnt0", 32'(bus.load_count), 0);
    chk("mid_stall", 32'(bus.fetch_stall), 1);
    chk("mid_rdy", 32'(bus.ld_ready), 1);
    chk("mid_bd", 32'(bus.boot_done), 0);
    chk("mid_en", 32'(bus.mem_en), 0);
    step();
    reset = 1'b0;
    ldw(0, 16'h0F0F, 1'b1);
    step();
    idle();
    fetch(32'd10);
    @(negedge clk);
    chk("reboot_bd", 32'(bus.boot_done), 1);
    chk("reboot_cnt", 32'(bus.load_count), 1);
    step();
    fetch(32'd4);
    @(negedge clk);
    chk("old_w5", 32'(bus.fetch_data), 32'h5555);
    step();
    idle();
    @(negedge clk);
    chk("old_w2", 32'(bus.fetch_data), 32'hDC67);
    step();

    // Full-depth boot without ld_last
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ldw(i, 16'(16'h1000 + i), 1'b0);
      @(negedge clk);
      chk("full_cnt", 32'(bus.load_count), 32'(i));
      chk("full_bd", 32'(bus.boot_done), 0);
      step();
    end
    ldw(3, 16'hBEEF, 1'b1);
    @(negedge clk);
    chk("full_bd8", 32'(bus.boot_done), 1);
    chk("full_cnt8", 32'(bus.load_count), 8);
    chk("p9_rdy", 32'(bus.ld_ready), 1);
    step();
    idle();
    fetch(32'd6);
    @(negedge clk);
    chk("p9_cnt", 32'(bus.load_count), 8);
    step();
    fetch(32'd14);
    @(negedge clk);
    chk("p9_fd", 32'(bus.fetch_data), 32'hBEEF);
    step();
    idle();
    @(negedge clk);
    chk("full_w7", 32'(bus.fetch_data), 32'h1007);
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
